// File: rtl/grid_port_arbiter.sv
// Grid_Mem port-A arbiter: round-robin/lock arbitration between game logic and line-clear engine, plus a full-grid clear sweep.
// Optional build macro GRID_INIT_CLEAR_EN: run a full clear sweep automatically out of reset.
module grid_port_arbiter #(
    parameter int         GRID_CELLS = 200,
    parameter logic [7:0] CLEAR_VAL  = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       g_req,
    input  logic       g_we,
    input  logic       g_lock,
    input  logic [7:0] g_addr,
    input  logic [7:0] g_wdata,
    output logic       g_gnt,
    output logic       g_rvalid,
    output logic [7:0] g_rdata,
    input  logic       l_req,
    input  logic       l_we,
    input  logic       l_lock,
    input  logic [7:0] l_addr,
    input  logic [7:0] l_wdata,
    output logic       l_gnt,
    output logic       l_rvalid,
    output logic [7:0] l_rdata,
    input  logic       clear_start,
    output logic       busy_clear,
    output logic       clear_done,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    input  logic [7:0] mem_q
);

    typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} state_t;

`ifdef GRID_INIT_CLEAR_EN
    localparam state_t RST_STATE = SWEEP;
`else
    localparam state_t RST_STATE = RUN;
`endif
    localparam logic [7:0] LAST_CELL = 8'(GRID_CELLS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic       r_last_l;
    logic       r_hold_g;
    logic       r_hold_l;
    logic       r_rd_g;
    logic       r_rd_l;
    logic       r_rvalid_g;
    logic       r_rvalid_l;
    logic       r_done;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_data;
    logic       r_mem_we;
    logic       w_gnt_g;
    logic       w_gnt_l;
    logic       w_sweep_last;

    // Grant: a locked holder keeps the port, otherwise ties go to whoever was not granted last.
    always_comb begin
        w_gnt_g = 1'b0;
        w_gnt_l = 1'b0;
        if (reset_n && (r_state == RUN)) begin
            if (r_hold_g && g_req) begin
                w_gnt_g = 1'b1;
            end else if (r_hold_l && l_req) begin
                w_gnt_l = 1'b1;
            end else if (g_req && l_req) begin
                w_gnt_g = r_last_l;
                w_gnt_l = ~r_last_l;
            end else begin
                w_gnt_g = g_req;
                w_gnt_l = l_req;
            end
        end else begin
            w_gnt_g = 1'b0;
            w_gnt_l = 1'b0;
        end
    end

    // Next-state logic for the RUN/SWEEP controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_last = (r_state == SWEEP) && (r_cnt == LAST_CELL);
        case (r_state)
            RUN: begin
                if (clear_start) begin
                    w_state_nxt = SWEEP;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            SWEEP: begin
                if (w_sweep_last) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = SWEEP;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Controller state, sweep counter and arbitration history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RST_STATE;
            r_cnt    <= 8'd0;
            r_last_l <= 1'b1;
            r_hold_g <= 1'b0;
            r_hold_l <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold_g <= w_gnt_g & g_lock;
            r_hold_l <= w_gnt_l & l_lock;
            r_done   <= w_sweep_last;
            if (w_gnt_g) begin
                r_last_l <= 1'b0;
            end else if (w_gnt_l) begin
                r_last_l <= 1'b1;
            end else begin
                r_last_l <= r_last_l;
            end
            if ((r_state == SWEEP) && !w_sweep_last) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // Issue stage plus two-deep read-return pipeline; reads in flight survive into a sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr <= 8'd0;
            r_mem_data <= 8'd0;
            r_mem_we   <= 1'b0;
            r_rd_g     <= 1'b0;
            r_rd_l     <= 1'b0;
            r_rvalid_g <= 1'b0;
            r_rvalid_l <= 1'b0;
        end else begin
            r_rd_g     <= w_gnt_g & ~g_we;
            r_rd_l     <= w_gnt_l & ~l_we;
            r_rvalid_g <= r_rd_g;
            r_rvalid_l <= r_rd_l;
            if (r_state == SWEEP) begin
                r_mem_addr <= r_cnt;
                r_mem_data <= CLEAR_VAL;
                r_mem_we   <= 1'b1;
            end else if (w_gnt_g) begin
                r_mem_addr <= g_addr;
                r_mem_data <= g_wdata;
                r_mem_we   <= g_we;
            end else if (w_gnt_l) begin
                r_mem_addr <= l_addr;
                r_mem_data <= l_wdata;
                r_mem_we   <= l_we;
            end else begin
                r_mem_we   <= 1'b0;
            end
        end
    end

    assign g_gnt      = w_gnt_g;
    assign l_gnt      = w_gnt_l;
    assign g_rvalid   = r_rvalid_g;
    assign l_rvalid   = r_rvalid_l;
    assign g_rdata    = mem_q;
    assign l_rdata    = mem_q;
    assign busy_clear = (r_state == SWEEP);
    assign clear_done = r_done;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;

endmodule

// File: doc/grid_port_arbiter.md
GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

Interface
REQ-001 SHALL have parameter GRID_CELLS, default 200: number of grid memory cells swept by a clear (1..256).
REQ-002 SHALL have parameter CLEAR_VAL, default 8'h00: value written to every cell during a clear sweep.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports g_req/g_we/g_lock  input  1 each  game-logic request, write enable, hold-grant.
REQ-006 SHALL have ports g_addr, g_wdata  input  8 each  game-logic address, write data.
REQ-007 SHALL have ports g_gnt, g_rvalid  output  1 each; g_rdata  output  8  game-logic grant, read-valid, read data.
REQ-008 SHALL have ports l_req/l_we/l_lock, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata, same widths and meaning as game-logic set, for the line-clear engine.
REQ-009 SHALL have port clear_start  input  1  one-cycle request to sweep the whole grid to CLEAR_VAL.
REQ-010 SHALL have ports busy_clear, clear_done  output  1 each  sweep in progress; one-cycle sweep-complete pulse.
REQ-011 SHALL have ports mem_addr, mem_data  output  8 each; mem_we  output  1; mem_q  input  8  Grid_Mem port A.

Function
REQ-012 SHALL implement FSM states RUN and SWEEP; RUN->SWEEP when clear_start=1 in RUN; SWEEP->RUN after the cell counter issues address GRID_CELLS-1.
REQ-013 SHALL, in RUN, drive g_gnt/l_gnt combinationally from current requests: at most one grant per cycle, never a grant without its req.
REQ-014 SHALL resolve simultaneous g_req and l_req round-robin: grant the requester not granted most recently; last-granted register resets to "l" so g wins the first tie.
REQ-015 SHALL, when the requester granted in cycle N had its lock=1, grant it again in N+1 if it still requests, regardless of round-robin.
REQ-016 SHALL register the granted access onto mem_addr/mem_data/mem_we in the cycle after grant (issue stage); mem_we=0 and mem_addr/mem_data hold last value when no access issued.
REQ-017 SHALL assert the requester's rvalid for exactly one cycle two cycles after a read grant (we=0), with rdata = mem_q in that cycle; writes produce no rvalid.
REQ-018 SHALL hold rdata outputs at mem_q continuously; only rvalid qualifies them.
REQ-019 SHALL, in SWEEP, grant nothing and issue one write per cycle: addresses 0..GRID_CELLS-1 ascending, data CLEAR_VAL, mem_we=1.
REQ-020 SHALL assert busy_clear = (state==SWEEP) and pulse clear_done one cycle in the first RUN cycle after a sweep.
REQ-021 SHALL ignore clear_start while in SWEEP and when sampled in the same cycle as a RUN grant: that grant completes, sweep begins next cycle.
REQ-022 SHALL deliver rvalid for a read granted in the last RUN cycle before a sweep, even though it lands during SWEEP.

Reset
REQ-023 SHALL, while reset_n=0, force g_gnt=l_gnt=0, g_rvalid=l_rvalid=0, mem_we=0, mem_addr=0, mem_data=0, clear_done=0, sweep counter=0, read pipeline cleared.
REQ-024 SHALL abort any sweep or pending read on reset assertion; no partial rvalid after release.

Configuration
REQ-025 SHALL, with GRID_INIT_CLEAR_EN defined, reset the FSM to SWEEP (busy_clear=1 in reset) so a full clear runs automatically on reset release.
REQ-026 SHALL, without GRID_INIT_CLEAR_EN, reset the FSM to RUN (busy_clear=0 in reset); sweeps occur only via clear_start.

Verification
REQ-027 Tie: g_req=l_req=1 reads to 8'h05/8'h06 for 4 cycles after reset -> grants g,l,g,l; mem_addr 05,06,05,06 one cycle later; rvalids two cycles after each grant.
REQ-028 Lock: g_req=g_lock=1 with l_req=1 for 3 cycles -> g_gnt 3 consecutive cycles, l_gnt 0; g_lock drops -> l granted next cycle.
REQ-029 Read latency: write 8'hA5 to 8'h10, then read 8'h10 -> g_rvalid=1 exactly 2 cycles after read grant with g_rdata=8'hA5.
REQ-030 Clear: pulse clear_start with GRID_CELLS=200 -> 200 writes of 8'h00 to addresses 0..199 on consecutive cycles, busy_clear high 200 cycles, requests ungranted, clear_done one pulse after.
REQ-031 Reset mid-sweep at address 8'd57 with GRID_INIT_CLEAR_EN -> mem_we=0 during reset; on release sweep restarts at address 0 and runs 200 cycles.
REQ-032 Build without GRID_INIT_CLEAR_EN -> busy_clear=0 after reset, g_req granted in first cycle after release.
